// File: rtl/uart_packet_rx.sv
// uart_packet_rx: frames raw UART bytes (SYNC, Dest, Src, Len, payload) into a Valid/SoP/EoP stream; payload 1 clock after its strobe, no backpressure.
// Define UART_PACKET_RX_TIMEOUT_EN to abort packets that stall for TIMEOUT_CYCLES idle clocks mid-packet.
module uart_packet_rx #(
   parameter logic [7:0] SYNC_BYTE      = 8'h55,
   parameter int         TIMEOUT_CYCLES = 50000,
   parameter int         ERR_WIDTH      = 8
) (
   input  logic                 ipClk,
   input  logic                 ipReset,
   input  logic [7:0]           ipRxData,
   input  logic                 ipRxValid,
   output logic [7:0]           opRxSource,
   output logic [7:0]           opRxDestination,
   output logic [7:0]           opRxLength,
   output logic [7:0]           opRxData,
   output logic                 opRxValid,
   output logic                 opRxSoP,
   output logic                 opRxEoP,
   output logic                 opRxAbort,
   output logic [ERR_WIDTH-1:0] opErrCount
);

   typedef enum logic [2:0] {IDLE, DEST, SRC, LEN, DATA} state_t;

   state_t     state;
   logic [7:0] remaining;
   logic       firstByte;

   if (TIMEOUT_CYCLES < 2 || ERR_WIDTH < 1) begin : gParamCheck
      $error("uart_packet_rx: TIMEOUT_CYCLES must be >= 2 and ERR_WIDTH >= 1");
   end

   function automatic logic [ERR_WIDTH-1:0] satInc(input logic [ERR_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

`ifdef UART_PACKET_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] timeoutCnt;
`else
   assign opRxAbort = 1'b0;
`endif

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         state           <= IDLE;
         remaining       <= '0;
         firstByte       <= 1'b0;
         opRxSource      <= '0;
         opRxDestination <= '0;
         opRxLength      <= '0;
         opRxData        <= '0;
         opRxValid       <= 1'b0;
         opRxSoP         <= 1'b0;
         opRxEoP         <= 1'b0;
         opErrCount      <= '0;
`ifdef UART_PACKET_RX_TIMEOUT_EN
         opRxAbort       <= 1'b0;
         timeoutCnt      <= '0;
`endif
      end else begin
         opRxValid <= 1'b0;
         opRxSoP   <= 1'b0;
         opRxEoP   <= 1'b0;
`ifdef UART_PACKET_RX_TIMEOUT_EN
         opRxAbort <= 1'b0;
         // Counts only idle clocks inside a packet; any byte restarts the window.
         if (state == IDLE || ipRxValid) timeoutCnt <= '0;
         else                            timeoutCnt <= timeoutCnt + 1'b1;
`endif
         if (ipRxValid) begin
            case (state)
               IDLE: begin
                  if (ipRxData == SYNC_BYTE) state <= DEST;
               end
               DEST: begin
                  opRxDestination <= ipRxData;
                  state           <= SRC;
               end
               SRC: begin
                  opRxSource <= ipRxData;
                  state      <= LEN;
               end
               LEN: begin
                  opRxLength <= ipRxData;
                  remaining  <= ipRxData;
                  firstByte  <= 1'b1;
                  if (ipRxData == 8'd0) begin
                     opErrCount <= satInc(opErrCount);
                     state      <= IDLE;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  // Sync-valued bytes here are payload; exit happens at remaining==1 so it never wraps.
                  opRxValid <= 1'b1;
                  opRxData  <= ipRxData;
                  opRxSoP   <= firstByte;
                  opRxEoP   <= (remaining == 8'd1);
                  firstByte <= 1'b0;
                  remaining <= remaining - 8'd1;
                  if (remaining == 8'd1) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
`ifdef UART_PACKET_RX_TIMEOUT_EN
         else if (state != IDLE && timeoutCnt == TimeoutLast) begin
            opRxAbort  <= 1'b1;
            opErrCount <= satInc(opErrCount);
            state      <= IDLE;
            timeoutCnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx; the timeout scenario follows UART_PACKET_RX_TIMEOUT_EN.
module tb_uart_packet_rx;

   logic       ipClk = 1'b0;
   logic       ipReset;
   logic [7:0] ipRxData;
   logic       ipRxValid;
   logic [7:0] opRxSource, opRxDestination, opRxLength, opRxData;
   logic       opRxValid, opRxSoP, opRxEoP, opRxAbort;
   logic [7:0] opErrCount;

   int nChecks = 0;
   int nBad    = 0;

   localparam logic [2:0] NONE = 3'b000;  // {valid, sop, eop}
   localparam logic [2:0] MID  = 3'b100;
   localparam logic [2:0] FST  = 3'b110;
   localparam logic [2:0] LST  = 3'b101;
   localparam logic [2:0] ONE  = 3'b111;

   uart_packet_rx #(
      .SYNC_BYTE      (8'h55),
      .TIMEOUT_CYCLES (16),
      .ERR_WIDTH      (8)
   ) dut (
      .ipClk           (ipClk),
      .ipReset         (ipReset),
      .ipRxData        (ipRxData),
      .ipRxValid       (ipRxValid),
      .opRxSource      (opRxSource),
      .opRxDestination (opRxDestination),
      .opRxLength      (opRxLength),
      .opRxData        (opRxData),
      .opRxValid       (opRxValid),
      .opRxSoP         (opRxSoP),
      .opRxEoP         (opRxEoP),
      .opRxAbort       (opRxAbort),
      .opErrCount      (opErrCount)
   );

   always #5 ipClk = ~ipClk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Strobe one byte, then look just after the edge that consumed it.
   task automatic rxByte(input logic [7:0] b, input logic [2:0] exp, input string tag);
      @(negedge ipClk);
      ipRxData  = b;
      ipRxValid = 1'b1;
      @(posedge ipClk);
      #1;
      check({tag, ".valid"}, opRxValid, exp[2]);
      check({tag, ".sop"},   opRxSoP,   exp[1]);
      check({tag, ".eop"},   opRxEoP,   exp[0]);
      if (exp[2]) check({tag, ".data"}, opRxData, b);
   endtask

   task automatic idleCycle(input string tag);
      @(negedge ipClk);
      ipRxValid = 1'b0;
      @(posedge ipClk);
      #1;
      check({tag, ".valid"}, opRxValid, 1'b0);
   endtask

   task automatic checkHdr(input string tag, input logic [7:0] d, input logic [7:0] s, input logic [7:0] l);
      check({tag, ".dest"}, opRxDestination, d);
      check({tag, ".src"},  opRxSource,      s);
      check({tag, ".len"},  opRxLength,      l);
   endtask

   task automatic normalPacket(input string tag);
      rxByte(8'h55, NONE, {tag, ".b0"});
      rxByte(8'h00, NONE, {tag, ".b1"});
      rxByte(8'h01, NONE, {tag, ".b2"});
      rxByte(8'h04, NONE, {tag, ".b3"});
      rxByte(8'hDE, FST,  {tag, ".b4"});
      rxByte(8'hAD, MID,  {tag, ".b5"});
      rxByte(8'hBE, MID,  {tag, ".b6"});
      rxByte(8'hEF, LST,  {tag, ".b7"});
      idleCycle({tag, ".tail"});
      checkHdr(tag, 8'h00, 8'h01, 8'h04);
   endtask

   task automatic checkAllZero(input string tag);
      checkHdr(tag, 8'h00, 8'h00, 8'h00);
      check({tag, ".data"},  opRxData,   8'h00);
      check({tag, ".valid"}, opRxValid,  1'b0);
      check({tag, ".sop"},   opRxSoP,    1'b0);
      check({tag, ".eop"},   opRxEoP,    1'b0);
      check({tag, ".abort"}, opRxAbort,  1'b0);
      check({tag, ".err"},   opErrCount, 8'd0);
   endtask

   initial begin
      ipReset   = 1'b1;
      ipRxData  = 8'h00;
      ipRxValid = 1'b0;
      repeat (3) @(posedge ipClk);
      @(negedge ipClk);
      ipReset = 1'b0;
      checkAllZero("rst");

      // Normal packet
      normalPacket("norm");
      check("norm.err", opErrCount, 8'd0);

      // Garbage then a 1-byte packet
      rxByte(8'h12, NONE, "garb.b0");
      rxByte(8'h34, NONE, "garb.b1");
      rxByte(8'h55, NONE, "garb.b2");
      rxByte(8'h01, NONE, "garb.b3");
      rxByte(8'h02, NONE, "garb.b4");
      rxByte(8'h01, NONE, "garb.b5");
      rxByte(8'h7F, ONE,  "garb.b6");
      idleCycle("garb.tail");
      checkHdr("garb", 8'h01, 8'h02, 8'h01);
      check("garb.err", opErrCount, 8'd0);

      // Zero length, then a packet straight after, then a sync-in-payload packet back to back with EoP
      rxByte(8'h55, NONE, "zero.b0");
      rxByte(8'h00, NONE, "zero.b1");
      rxByte(8'h01, NONE, "zero.b2");
      rxByte(8'h00, NONE, "zero.b3");
      check("zero.err", opErrCount, 8'd1);
      rxByte(8'h55, NONE, "zero2.b0");
      rxByte(8'h00, NONE, "zero2.b1");
      rxByte(8'h01, NONE, "zero2.b2");
      rxByte(8'h01, NONE, "zero2.b3");
      rxByte(8'hAA, ONE,  "zero2.b4");
      rxByte(8'h55, NONE, "sync.b0");
      rxByte(8'h00, NONE, "sync.b1");
      rxByte(8'h01, NONE, "sync.b2");
      rxByte(8'h02, NONE, "sync.b3");
      rxByte(8'h55, FST,  "sync.b4");
      rxByte(8'h66, LST,  "sync.b5");
      idleCycle("sync.tail");
      checkHdr("sync", 8'h00, 8'h01, 8'h02);
      check("sync.err", opErrCount, 8'd1);

      // Reset mid-packet
      rxByte(8'h55, NONE, "mid.b0");
      rxByte(8'h00, NONE, "mid.b1");
      rxByte(8'h01, NONE, "mid.b2");
      rxByte(8'h04, NONE, "mid.b3");
      rxByte(8'h11, FST,  "mid.b4");
      @(negedge ipClk);
      ipRxValid = 1'b0;
      ipReset   = 1'b1;
      @(negedge ipClk);
      ipReset = 1'b0;
      checkAllZero("midrst");
      idleCycle("midrst.idle");
      normalPacket("post");
      check("post.err", opErrCount, 8'd0);

      // Stalled packet
      rxByte(8'h55, NONE, "to.b0");
      rxByte(8'h00, NONE, "to.b1");
      rxByte(8'h01, NONE, "to.b2");
      rxByte(8'h03, NONE, "to.b3");
      rxByte(8'h11, FST,  "to.b4");
      for (int k = 1; k <= 20; k++) begin
         idleCycle($sformatf("to.idle%0d", k));
`ifdef UART_PACKET_RX_TIMEOUT_EN
         check($sformatf("to.abort%0d", k), opRxAbort, (k == 16));
`else
         check($sformatf("to.abort%0d", k), opRxAbort, 1'b0);
`endif
      end
`ifdef UART_PACKET_RX_TIMEOUT_EN
      check("to.err", opErrCount, 8'd1);
      rxByte(8'h55, NONE, "after.b0");
      rxByte(8'h09, NONE, "after.b1");
      rxByte(8'h08, NONE, "after.b2");
      rxByte(8'h01, NONE, "after.b3");
      rxByte(8'hAA, ONE,  "after.b4");
      idleCycle("after.tail");
      checkHdr("after", 8'h09, 8'h08, 8'h01);
      check("after.err", opErrCount, 8'd1);
`else
      rxByte(8'h22, MID, "wait.b5");
      rxByte(8'h33, LST, "wait.b6");
      idleCycle("wait.tail");
      check("wait.err", opErrCount, 8'd0);
`endif

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule

// File: doc/uart_packet_rx.md
Name: uart_packet_rx

Overview:
- Upstream packetiser between the UART receiver and the stream controller.
- Consumes raw received bytes and frames them into the team's UART packet stream: sync byte, Destination, Source, Length, then Length payload bytes.
- Drives Valid/SoP/EoP per payload byte.
- Counts framing errors and, optionally, aborts packets stalled by an inter-byte timeout.

Parameters:
- SYNC_BYTE, 8'h55, start-of-packet marker.
- TIMEOUT_CYCLES, 50000, idle clocks between bytes before mid-packet abort; used only with the macro.
- ERR_WIDTH, 8, width of the error counter.

Ports:
- ipClk  input  1  system clock.
- ipReset  input  1  synchronous, active-high reset.
- ipRxData  input  8  byte from UART receiver.
- ipRxValid  input  1  one-cycle strobe; ipRxData is valid this cycle.
- opRxSource  output  8  Source field of current packet.
- opRxDestination  output  8  Destination field of current packet.
- opRxLength  output  8  Length field of current packet.
- opRxData  output  8  payload byte.
- opRxValid  output  1  opRxData valid, one-cycle pulse per byte.
- opRxSoP  output  1  first payload byte of packet; qualified by opRxValid.
- opRxEoP  output  1  last payload byte of packet; qualified by opRxValid.
- opRxAbort  output  1  one-cycle pulse; current packet aborted.
- opErrCount  output  ERR_WIDTH  saturating framing-error count.

Behaviour:
- Clock and reset: one clock, ipClk. Reset is synchronous, active-high, on ipReset.
- Reset values:
  - all outputs 0.
  - state IDLE, byte counter 0, timeout counter 0.
  - reset mid-packet discards the partial packet with no opRxAbort pulse.
- Handshake:
  - no backpressure; every byte with ipRxValid=1 is consumed that cycle.
  - ipRxValid may be high on consecutive cycles.
- Header outputs: opRxSource, opRxDestination, opRxLength are registered when each header byte arrives and hold until overwritten by the next packet.
- States (transitions occur only on ipRxValid=1 unless noted):
  - IDLE: byte == SYNC_BYTE -> DEST. Any other byte: stay, no error.
  - DEST: latch opRxDestination -> SRC.
  - SRC: latch opRxSource -> LEN.
  - LEN: latch opRxLength, load remaining = byte.
    - byte == 0: opErrCount += 1 (saturate at all-ones) -> IDLE; no payload output.
    - byte != 0 -> DATA, first-byte flag set.
  - DATA:
    - each byte: next cycle opRxValid=1 and opRxData=byte.
    - opRxSoP=1 on the first byte; opRxEoP=1 when remaining == 1.
    - remaining decrements per byte.
    - on EoP -> IDLE.
    - Length 1 gives SoP and EoP on the same cycle.
- Latency: payload byte appears exactly 1 clock after its ipRxValid strobe. Valid/SoP/EoP are single-cycle pulses.
- Sync value in payload: a byte equal to SYNC_BYTE inside DATA is payload. There is no resync mid-packet.
- Counter widths: remaining is 8 bits, so maximum payload is 255. No wrap, because DATA exits at remaining == 1.
- Back-to-back packets: a SYNC byte arriving on the cycle right after EoP is accepted (FSM already in IDLE).

Optional Feature:
- Macro: UART_PACKET_RX_TIMEOUT_EN.
- Defined:
  - counter increments every clock while state != IDLE and ipRxValid=0; clears on ipRxValid or in IDLE.
  - reaching TIMEOUT_CYCLES-1 -> next cycle opRxAbort=1, opErrCount += 1 (saturating), state -> IDLE.
  - if ipRxValid coincides with the terminal count, the byte wins and the counter clears.
- Undefined: no counter logic; opRxAbort is tied 0 and the FSM waits indefinitely.

Test Plan:
- Normal packet: bytes 55,00,01,04,DE,AD,BE,EF.
  - Expect Destination=00, Source=01, Length=04.
  - 4 Valid pulses carrying DE,AD,BE,EF, each 1 clock after its strobe.
  - SoP with DE, EoP with EF; opErrCount stays 0.
- Garbage then packet: bytes 12,34,55,01,02,01,7F.
  - Leading bytes ignored; single Valid with SoP=EoP=1, Data=7F; opErrCount 0.
- Zero length: 55,00,01,00 then 55,00,01,01,AA.
  - opErrCount=1; first packet emits nothing; second emits AA with SoP=EoP=1.
- Sync inside payload: 55,00,01,02,55,66.
  - Valid pulses Data=55 (SoP), then Data=66 (EoP).
- Reset mid-packet: 55,00,01,04,11, assert ipReset for 1 cycle, then full normal packet.
  - No Valid for the aborted packet after reset; all outputs 0 after reset; second packet correct.
- Timeout (macro defined, TIMEOUT_CYCLES=16): 55,00,01,03,11 then 20 idle cycles.
  - Valid for 11 only; opRxAbort pulses once, 16 clocks after byte 11.
  - opErrCount=1; next packet parses normally.
